jtkunio_scr_rom: RTL

JTKUNIO_SCR_ROM -- requirements
Module: jtkunio_scr_rom

---
 rtl/jtkunio_scr_rom.sv | 121 ++++++++++++
 1 files changed

// File: rtl/jtkunio_scr_rom.sv
// Scroll-layer ROM adapter: one-entry 32-bit cache filled by two 16-bit
// external memory reads, low half first.
module jtkunio_scr_rom #(
  parameter int          AW     = 17,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [AW-2:0] pend_q, pend_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          req_q, req_d;
  logic [21:0]   addr_q, addr_d;
  logic          hit;

  // Bit 0 selects nothing: the pair of 16-bit halves is always fetched.
  logic unused_addr_lsb;
  assign unused_addr_lsb = rom_addr[0];

  assign hit        = valid_q && (tag_q == rom_addr[AW-1:1]);
  assign rom_ok     = rom_cs && hit;
  assign rom_data   = data_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (rom_cs && !hit) begin
          pend_d  = rom_addr[AW-1:1];
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = OFFSET + 22'({rom_addr[AW-1:1], 1'b0});
          state_d = REQ_LO;
        end
      end
      // In request states only the ack matters; a coincident rdy is dropped.
      REQ_LO: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (sdram_rdy) begin
          data_d[15:0] = sdram_din;
          req_d        = 1'b1;
          addr_d       = OFFSET + 22'({pend_q, 1'b1});
          state_d      = REQ_HI;
        end
      end
      REQ_HI: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (sdram_rdy) begin
          data_d[31:16] = sdram_din;
          tag_d         = pend_q;
          valid_d       = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      req_q   <= 1'b0;
      addr_q  <= 22'h0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

endmodule
